refill_arbiter: RTL and testbench
=================================

# refill_arbiter

Shares the single cache-refill Fetch engine, and through it the main-memory read port, between the instruction-cache and data-cache miss paths. Each requester raises a level request with a miss address. The arbiter grants one requester at a time and issues a one-cycle start with a line-aligned address to the Fetch engine. It returns a one-cycle done pulse to the granted requester, and a watchdog converts a hung refill into an error response.

## Interface
- `TIMEOUT_CYC`, default 32: WAIT cycles allowed before a refill is declared hung; legal range 11..255.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: I-cache refill request; a level, held until `i_done`.
- `i_addr` in 32: I-cache miss address; stable while `i_req` is high.
- `i_done` out 1: one-cycle pulse ending the I-cache request.
- `d_req` in 1: D-cache refill request; same rules as `i_req`.
- `d_addr` in 32: D-cache miss address; same rules as `i_addr`.
- `d_done` out 1: one-cycle pulse ending the D-cache request.
- `f_start` out 1: start pulse to the Fetch engine.
- `f_addr` out 32: refill address to the Fetch engine, `{addr[31:5], 5'b0}`.
- `f_done` in 1: done pulse from the Fetch engine.
- `busy` out 1: high in every state except IDLE.
- `owner` out 1: current or last grantee, 0 = I-cache, 1 = D-cache.
- `err` out 1: pulses together with the `*_done` of a timed-out refill.

## Operation
- States are IDLE, START, WAIT and RESP.
- IDLE:
  - With no request, stay in IDLE.
  - With exactly one request, grant that requester.
  - With both requests, grant the requester not equal to `last_owner` (round-robin).
  - On a grant, register `owner` and `f_addr` from the winner, then go to START.
- START:
  - `f_start`=1 for exactly this cycle.
  - Go to WAIT and clear the watchdog counter.
- WAIT:
  - If `f_done`=1, go to RESP with `err`=0.
  - Otherwise, if the counter equals `TIMEOUT_CYC`-1, go to RESP with `err`=1.
  - Otherwise, increment the counter.
- RESP:
  - Assert the `*_done` selected by `owner` for one cycle; `err` is high in the same cycle on timeout.
  - Update `last_owner` to `owner` and go to IDLE.
- `f_addr` holds its value from START through RESP. The Fetch engine reads the address combinationally throughout its burst, so the value must not change mid-burst.
- `f_done` arriving in IDLE, START or RESP is ignored; this covers a stray done after a timeout.
- Requests are not re-sampled after the grant. Dropping `*_req` before `*_done` is illegal, and the arbiter still completes the transaction.
- Reset values:
  - State is IDLE; `f_start`, `i_done`, `d_done`, `busy` and `err` are 0.
  - `f_addr` is 0 and `owner` is 0.
  - `last_owner` is 1, so the I-cache wins the first tie.
- An `rst_n` assertion mid-transaction aborts immediately, with no done pulse. The Fetch engine must be reset in the same cycle; the top level ties both resets to the same source.

## Timing
- Request latency:
  - Request seen in IDLE at cycle 0, `f_start` in cycle 1.
  - The Fetch engine runs 8 FETCH cycles (2..9) and 1 DONE cycle (10), then raises `f_done` in cycle 11.
  - `*_done` is high in cycle 12.
- Back-to-back throughput is one refill per 13 cycles. The requester drops `*_req` on the edge closing RESP, so IDLE in cycle 13 sees the new state.
- A timeout gives `*_done` and `err` at cycle 2+`TIMEOUT_CYC`.
- All outputs are registered; no combinational path from any input to any output.
- The watchdog counter is 8 bits, and its compare is exact equality.

## Structure
- Shared package `cache_pkg` holds:
  - state encoding `REFILL_IDLE`/`START`/`WAIT`/`RESP` (2 bits);
  - `OWNER_I`=0 and `OWNER_D`=1;
  - `LINE_WORDS`=8, `LINE_OFFSET_W`=5 and `FETCH_LATENCY`=10.
- One sub-module is natural: `refill_watchdog`, an 8-bit counter with clear, enable and a terminal-count flag.
- The round-robin pick stays inline.

## Test plan
- Single I refill: `i_req`=1, `i_addr`=0x0000_1234 → `f_start` in cycle 1 with `f_addr`=0x0000_1220; `i_done` in cycle 12; `err`=0; `d_done` never asserts.
- Simultaneous first requests: `i_req`=`d_req`=1 from reset → I is served first (`i_done` at 12), then D (`f_start` at 14, `d_done` at 25).
- Round-robin fairness: both requests held continuously for 4 grants → owner sequence I, D, I, D.
- Timeout: the Fetch model never asserts `f_done`, `d_req`=1, `TIMEOUT_CYC`=32 → `d_done`=`err`=1 in cycle 34; a stray `f_done` later in IDLE causes no pulse.
- Reset mid-WAIT: `rst_n` low at cycle 6 → all outputs 0 immediately; a request after release restarts with the full 12-cycle latency.
- Address stability: randomly toggle the non-granted requester's address during WAIT → `f_addr` is constant from START through RESP.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache refill definitions: refill FSM encoding, owner codes, line geometry
// and the grant payload carried from the arbiter's grant decision to the Fetch engine.
package cache_pkg;

  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned LINE_WORDS    = 8;
  localparam int unsigned LINE_OFFSET_W = $clog2(LINE_WORDS * 4);
  localparam int unsigned FETCH_LATENCY = 10;
  localparam int unsigned WDOG_W        = 8;

  typedef enum logic [1:0] {
    REFILL_IDLE  = 2'd0,
    REFILL_START = 2'd1,
    REFILL_WAIT  = 2'd2,
    REFILL_RESP  = 2'd3
  } refill_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Grant payload: who owns the Fetch engine and which line it fetches.
  typedef struct packed {
    logic              owner;
    logic [ADDR_W-1:0] addr;
  } refill_grant_t;

  // Clear the byte offset within a cache line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:LINE_OFFSET_W], LINE_OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/refill_watchdog.sv
// Refill watchdog: 8-bit cycle counter with synchronous clear and enable; flags
// the cycle in which the count reaches TIMEOUT_CYC-1.
//   clk, rst_n : clock, async active-low reset
//   i_clear    : zero the counter (takes priority over i_en)
//   i_en       : increment the counter
//   o_tc_c     : combinational terminal-count flag (count == TIMEOUT_CYC-1)
module refill_watchdog
  import cache_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc_c
);

  logic [WDOG_W-1:0] r_cnt;

  // Cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + WDOG_W'(1);
    end
  end

  assign o_tc_c = (r_cnt == WDOG_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/refill_arbiter.sv
// Refill arbiter: shares one Fetch engine between the I-cache and D-cache miss
// paths with round-robin arbitration and a watchdog that turns a hung refill
// into an error response.
//   i_req/i_addr/i_done : I-cache request level, miss address, done pulse
//   d_req/d_addr/d_done : D-cache request level, miss address, done pulse
//   f_start/f_addr      : Fetch engine start pulse and line-aligned address
//   f_done              : Fetch engine completion pulse
//   busy, owner, err    : not-idle flag, current/last grantee, timeout flag
module refill_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_done,
  output logic              f_start,
  output logic [ADDR_W-1:0] f_addr,
  input  logic              f_done,
  output logic              busy,
  output logic              owner,
  output logic              err
);

  refill_state_t r_state;
  refill_state_t w_state_nxt;
  refill_grant_t r_grant;
  refill_grant_t w_grant_nxt;
  logic          r_last_owner;
  logic          w_last_owner_nxt;
  logic          w_winner;
  logic          w_tc;
  logic          w_wdog_clear;
  logic          w_wdog_en;
  logic          w_f_start_nxt;
  logic          w_i_done_nxt;
  logic          w_d_done_nxt;
  logic          w_err_nxt;
  logic          w_busy_nxt;

  refill_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_wdog_clear),
    .i_en    (w_wdog_en),
    .o_tc_c  (w_tc)
  );

  // Round-robin pick: a tie goes to the requester that did not win last time.
  assign w_winner = (i_req && d_req) ? ~r_last_owner : d_req;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REFILL_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      REFILL_IDLE:  if (i_req || d_req) w_state_nxt = REFILL_START;
      REFILL_START: w_state_nxt = REFILL_WAIT;
      REFILL_WAIT:  if (f_done || w_tc) w_state_nxt = REFILL_RESP;
      REFILL_RESP:  w_state_nxt = REFILL_IDLE;
      default:      w_state_nxt = REFILL_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and watchdog controls.
  always_comb begin
    w_f_start_nxt    = 1'b0;
    w_i_done_nxt     = 1'b0;
    w_d_done_nxt     = 1'b0;
    w_err_nxt        = 1'b0;
    w_busy_nxt       = (w_state_nxt != REFILL_IDLE);
    w_grant_nxt      = r_grant;
    w_last_owner_nxt = r_last_owner;
    w_wdog_clear     = 1'b0;
    w_wdog_en        = 1'b0;
    case (r_state)
      REFILL_IDLE: begin
        if (i_req || d_req) begin
          w_f_start_nxt     = 1'b1;
          w_grant_nxt.owner = w_winner;
          w_grant_nxt.addr  = line_align((w_winner == OWNER_D) ? d_addr : i_addr);
        end
      end
      REFILL_START: w_wdog_clear = 1'b1;
      REFILL_WAIT: begin
        w_wdog_en = 1'b1;
        // A real completion wins over a coincident watchdog expiry.
        if (f_done || w_tc) begin
          w_i_done_nxt = (r_grant.owner == OWNER_I);
          w_d_done_nxt = (r_grant.owner == OWNER_D);
          w_err_nxt    = ~f_done;
        end
      end
      REFILL_RESP: w_last_owner_nxt = r_grant.owner;
      default: ;
    endcase
  end

  // Registered outputs and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_start      <= 1'b0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      r_grant      <= '0;
      r_last_owner <= OWNER_D;
    end else begin
      f_start      <= w_f_start_nxt;
      i_done       <= w_i_done_nxt;
      d_done       <= w_d_done_nxt;
      err          <= w_err_nxt;
      busy         <= w_busy_nxt;
      r_grant      <= w_grant_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  assign owner  = r_grant.owner;
  assign f_addr = r_grant.addr;

endmodule

// File: tb/tb_refill_arbiter.sv
// Bench for refill_arbiter: a Fetch engine model plus a transaction-level
// reference model (grant cycle, start/done cycle arithmetic) checked every cycle.
module tb_refill_arbiter;
  import cache_pkg::*;

  localparam int unsigned TB_TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic        d_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] d_addr = '0;
  logic        f_done;
  logic        fe_done = 1'b0;
  logic        stray_done = 1'b0;
  logic        hang = 1'b0;
  int          fe_cnt = 0;
  logic        i_done, d_done, f_start, busy, owner, err;
  logic [31:0] f_addr;
  logic [37:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: one transaction in flight at most.
  int          m_cyc;
  bit          m_active, m_last, m_owner, m_to;
  logic [31:0] m_addr;
  int          m_start, m_done;
  logic [37:0] e_vec;
  bit          e_i_done_b, e_d_done_b;

  always #5 clk = ~clk;

  assign f_done = fe_done | stray_done;
  assign obs    = {f_start, i_done, d_done, err, busy, owner, f_addr};

  refill_arbiter #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_done (i_done),
    .d_req  (d_req),
    .d_addr (d_addr),
    .d_done (d_done),
    .f_start(f_start),
    .f_addr (f_addr),
    .f_done (f_done),
    .busy   (busy),
    .owner  (owner),
    .err    (err)
  );

  // Fetch engine: f_done FETCH_LATENCY cycles after f_start, unless hung.
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      fe_cnt  = 0;
      fe_done = 1'b0;
    end else begin
      fe_done = 1'b0;
      if (fe_cnt > 0) begin
        fe_cnt--;
        if (fe_cnt == 0 && !hang) fe_done = 1'b1;
      end
      if (f_start) fe_cnt = FETCH_LATENCY;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish, got running, need finished");
    $fatal(1);
  end

  task automatic model_reset();
    m_cyc    = 0;
    m_active = 1'b0;
    m_last   = 1'b1;
    m_owner  = 1'b0;
    m_addr   = '0;
    m_start  = 0;
    m_done   = 0;
    m_to     = 1'b0;
  endtask

  // Expected outputs for the current cycle, then the grant decision for the next.
  task automatic model_step();
    bit dn;
    dn = m_active && (m_cyc == m_done);
    e_i_done_b = dn && !m_owner;
    e_d_done_b = dn && m_owner;
    e_vec = {m_active && (m_cyc == m_start), e_i_done_b, e_d_done_b, dn && m_to,
             m_active && (m_cyc >= m_start), m_owner, m_addr};
    if (dn) begin
      m_active = 1'b0;
      m_last   = m_owner;
    end else if (!m_active && (i_req || d_req)) begin
      m_owner  = (i_req && d_req) ? !m_last : d_req;
      m_addr   = (m_owner ? d_addr : i_addr) & 32'hFFFF_FFE0;
      m_start  = m_cyc + 1;
      m_to     = hang;
      m_done   = m_start + (hang ? int'(TB_TIMEOUT) + 1 : int'(FETCH_LATENCY) + 1);
      m_active = 1'b1;
    end
    m_cyc++;
  endtask

  // Requester behaviour: drop after the done pulse, optionally raise new random
  // requests and scramble the address of a requester that is not being served.
  task automatic drive_reqs(input bit hold, input int spawn_pct, input bit toggle);
    if (e_i_done_b && !hold) i_req = 1'b0;
    else if (!i_req && int'($urandom_range(99)) < spawn_pct) begin
      i_req = 1'b1; i_addr = $urandom;
    end
    if (e_d_done_b && !hold) d_req = 1'b0;
    else if (!d_req && int'($urandom_range(99)) < spawn_pct) begin
      d_req = 1'b1; d_addr = $urandom;
    end
    if (toggle && i_req && !(m_active && !m_owner) && $urandom_range(1) == 1) i_addr = $urandom;
    if (toggle && d_req && !(m_active && m_owner) && $urandom_range(1) == 1) d_addr = $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; stray_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    e_i_done_b = 1'b0;
    e_d_done_b = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 38'd0) begin
      n_fail++; $display("FAIL reset_state got %h need %h", obs, 38'd0);
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (obs !== 38'd0) begin
      n_fail++; $display("FAIL reset_release got %h need %h", obs, 38'd0);
    end
  endtask

  task automatic test_single_i();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin i_req = 1'b1; i_addr = 32'h0000_1234; end
      else drive_reqs(1'b0, 0, 1'b0);
      @(negedge clk);
      model_step();
      n_checks++;
      if (obs !== e_vec) begin
        n_fail++; $display("FAIL single_i c=%0d got %h need %h", c, obs, e_vec);
      end
      if (c == 1) begin
        n_checks++;
        if ({f_start, f_addr} !== {1'b1, 32'h0000_1220}) begin
          n_fail++; $display("FAIL single_i_start got %b/%h need 1/00001220", f_start, f_addr);
        end
      end
      if (c == 12) begin
        n_checks++;
        if ({i_done, d_done, err} !== 3'b100) begin
          n_fail++; $display("FAIL single_i_done got %b need 100", {i_done, d_done, err});
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] da;
    do_reset();
    da = 32'hABCD_0077;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin i_req = 1'b1; i_addr = 32'h0000_4000; d_req = 1'b1; d_addr = da; end
      else drive_reqs(1'b0, 0, 1'b0);
      @(negedge clk);
      model_step();
      n_checks++;
      if (obs !== e_vec) begin
        n_fail++; $display("FAIL simul c=%0d got %h need %h", c, obs, e_vec);
      end
      if (c == 12 || c == 14 || c == 25) begin
        n_checks++;
        if ({f_start, i_done, d_done} !== ((c == 12) ? 3'b010 : (c == 14) ? 3'b100 : 3'b001)) begin
          n_fail++; $display("FAIL simul_timing c=%0d got %b", c, {f_start, i_done, d_done});
        end
      end
    end
    n_checks++;
    if (f_addr !== 32'hABCD_0060) begin
      n_fail++; $display("FAIL simul_daddr got %h need abcd0060", f_addr);
    end
  endtask

  task automatic test_round_robin();
    bit q[$];
    do_reset();
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin i_req = 1'b1; d_req = 1'b1; i_addr = $urandom; d_addr = $urandom; end
      else drive_reqs(1'b1, 0, 1'b0);
      @(negedge clk);
      model_step();
      n_checks++;
      if (obs !== e_vec) begin
        n_fail++; $display("FAIL rr c=%0d got %h need %h", c, obs, e_vec);
      end
      if (f_start === 1'b1) q.push_back(owner);
    end
    n_checks++;
    if (q.size() != 4) begin
      n_fail++; $display("FAIL rr_count got %0d grants need 4", q.size());
    end
    for (int k = 0; k < q.size() && k < 4; k++) begin
      n_checks++;
      if (q[k] !== k[0]) begin
        n_fail++; $display("FAIL rr_order grant %0d got owner %0d need %0d", k, q[k], k[0]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    hang = 1'b1;
    for (int c = 0; c < 46; c++) begin
      @(posedge clk); #1;
      stray_done = (c == 38);
      if (c == 0) begin d_req = 1'b1; d_addr = 32'h8000_003F; end
      else drive_reqs(1'b0, 0, 1'b0);
      @(negedge clk);
      model_step();
      n_checks++;
      if (obs !== e_vec) begin
        n_fail++; $display("FAIL timeout c=%0d got %h need %h", c, obs, e_vec);
      end
      if (c == 34) begin
        n_checks++;
        if ({i_done, d_done, err} !== 3'b011) begin
          n_fail++; $display("FAIL timeout_resp got %b need 011", {i_done, d_done, err});
        end
      end
    end
    stray_done = 1'b0;
    hang = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin i_req = 1'b1; i_addr = $urandom; end
      @(negedge clk);
      model_step();
      n_checks++;
      if (obs !== e_vec) begin
        n_fail++; $display("FAIL midrst c=%0d got %h need %h", c, obs, e_vec);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 38'd0) begin
      n_fail++; $display("FAIL midrst_abort got %h need 0", obs);
    end
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin i_req = 1'b1; i_addr = 32'h0000_0F00; end
      else drive_reqs(1'b0, 0, 1'b0);
      @(negedge clk);
      model_step();
      n_checks++;
      if (obs !== e_vec) begin
        n_fail++; $display("FAIL midrst_restart c=%0d got %h need %h", c, obs, e_vec);
      end
      if (c == 11 || c == 12) begin
        n_checks++;
        if (i_done !== (c == 12)) begin
          n_fail++; $display("FAIL midrst_latency c=%0d got i_done %b", c, i_done);
        end
      end
    end
  endtask

  task automatic test_random_traffic();
    for (int p = 0; p < 2; p++) begin
      do_reset();
      hang = p[0];
      for (int c = 0; c < 500; c++) begin
        @(posedge clk); #1;
        drive_reqs(1'b0, 30, 1'b1);
        @(negedge clk);
        model_step();
        n_checks++;
        if (obs !== e_vec) begin
          n_fail++; $display("FAIL random p=%0d c=%0d got %h need %h", p, c, obs, e_vec);
        end
      end
    end
    hang = 1'b0;
  endtask

  initial begin
    model_reset();
    e_i_done_b = 1'b0;
    e_d_done_b = 1'b0;
    test_reset();
    test_single_i();
    test_simultaneous();
    test_round_robin();
    test_timeout();
    test_reset_mid_wait();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
